// File: rtl/traffic_phase_sequencer.sv
// Two-road timed intersection controller: registered 5-bit phase code plus R/Y/G lamp drives.
// Optional maintenance flash mode is compiled in with FLASH_MODE_EN.
module traffic_phase_sequencer #(
  parameter int TICK_DIV    = 100000000,
  parameter int T_MIN_GREEN = 5,
  parameter int T_MAX_GREEN = 10,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_REDYEL    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sa,
  input  logic       sb,
  input  logic       maint,
  output logic [4:0] phase_idx,
  output logic       phase_chg,
  output logic [2:0] lights_a,
  output logic [2:0] lights_b
);

  typedef enum logic [4:0] {
    A_GREEN   = 5'd0,
    A_YELLOW  = 5'd1,
    ALLRED_AB = 5'd2,
    B_REDYEL  = 5'd3,
    B_GREEN   = 5'd4,
    B_YELLOW  = 5'd5,
    ALLRED_BA = 5'd6,
    A_REDYEL  = 5'd7,
    FLASH_ON  = 5'd16,
    FLASH_OFF = 5'd17
  } phase_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (T_MAX_GREEN > 0) ? $clog2(T_MAX_GREEN + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] D_SAT    = DW'(T_MAX_GREEN);
  localparam logic [DW:0]   MIN_L    = (DW+1)'(T_MIN_GREEN);
  localparam logic [DW:0]   MAX_L    = (DW+1)'(T_MAX_GREEN);
  localparam logic [DW:0]   YEL_L    = (DW+1)'(T_YELLOW);
  localparam logic [DW:0]   AR_L     = (DW+1)'(T_ALLRED);
  localparam logic [DW:0]   RY_L     = (DW+1)'(T_REDYEL);

  phase_t        state, next_state, seq_next;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [DW-1:0] dwell, dwell_next;
  logic [DW:0]   len;
  logic          phase_end;
  logic [1:0]    sa_sync, sb_sync;
  logic          sa_s, sb_s;
  logic [2:0]    la_next, lb_next;

  assign tick = (pre_cnt == PRE_LAST);
  assign sa_s = sa_sync[1];
  assign sb_s = sb_sync[1];
  assign len  = {1'b0, dwell} + (DW+1)'(1);

`ifdef FLASH_MODE_EN
  logic [1:0] maint_sync;
  logic       maint_s;
  assign maint_s = maint_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) maint_sync <= '0;
    else       maint_sync <= {maint_sync[0], maint};
  end
`else
  logic unused_maint;
  assign unused_maint = maint;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa_sync <= '0;
      sb_sync <= '0;
      pre_cnt <= '0;
    end else begin
      sa_sync <= {sa_sync[0], sa};
      sb_sync <= {sb_sync[0], sb};
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end
  end

  // Phase end condition and successor in the fixed 0..7 ring.
  always_comb begin
    phase_end = 1'b0;
    seq_next  = ALLRED_BA;
    unique case (state)
      A_GREEN:   begin phase_end = (len >= MIN_L && sb_s) || (len >= MAX_L); seq_next = A_YELLOW;  end
      A_YELLOW:  begin phase_end = (len == YEL_L);                            seq_next = ALLRED_AB; end
      ALLRED_AB: begin phase_end = (len == AR_L);                             seq_next = B_REDYEL;  end
      B_REDYEL:  begin phase_end = (len == RY_L);                             seq_next = B_GREEN;   end
      B_GREEN:   begin phase_end = (len >= MIN_L && sa_s) || (len >= MAX_L); seq_next = B_YELLOW;  end
      B_YELLOW:  begin phase_end = (len == YEL_L);                            seq_next = ALLRED_BA; end
      ALLRED_BA: begin phase_end = (len == AR_L);                             seq_next = A_REDYEL;  end
      A_REDYEL:  begin phase_end = (len == RY_L);                             seq_next = A_GREEN;   end
      default:   begin phase_end = 1'b1;                                      seq_next = ALLRED_BA; end
    endcase
  end

  always_comb begin
    next_state = state;
    if (tick) begin
`ifdef FLASH_MODE_EN
      // Maintenance overrides every phase; leaving flash resumes via the B->A clearance.
      if (state == FLASH_ON || state == FLASH_OFF)
        next_state = maint_s ? ((state == FLASH_ON) ? FLASH_OFF : FLASH_ON) : ALLRED_BA;
      else if (maint_s)
        next_state = FLASH_ON;
      else if (phase_end)
        next_state = seq_next;
`else
      if (phase_end)
        next_state = seq_next;
`endif
    end
  end

  always_comb begin
    dwell_next = dwell;
    if (tick) begin
      if (next_state != state)  dwell_next = '0;
      else if (dwell != D_SAT)  dwell_next = dwell + DW'(1);
    end
  end

  always_comb begin
    la_next = 3'b100;
    lb_next = 3'b100;
    unique case (next_state)
      A_GREEN:   la_next = 3'b001;
      A_YELLOW:  la_next = 3'b010;
      B_REDYEL:  lb_next = 3'b110;
      B_GREEN:   lb_next = 3'b001;
      B_YELLOW:  lb_next = 3'b010;
      A_REDYEL:  la_next = 3'b110;
      FLASH_ON:  begin la_next = 3'b010; lb_next = 3'b010; end
      FLASH_OFF: begin la_next = 3'b000; lb_next = 3'b000; end
      default:   begin la_next = 3'b100; lb_next = 3'b100; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ALLRED_BA;
      dwell     <= '0;
      phase_chg <= 1'b0;
      lights_a  <= 3'b100;
      lights_b  <= 3'b100;
    end else begin
      state     <= next_state;
      dwell     <= dwell_next;
      phase_chg <= (next_state != state);
      lights_a  <= la_next;
      lights_b  <= lb_next;
    end
  end

  assign phase_idx = state;

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Timed two-road intersection controller (road A, road B) with car sensors. Produces a registered 5-bit phase index that feeds the 5-to-32 one-hot phase decoder directly, plus direct R/Y/G lamp drives. Runs from the board clock with an internal prescaler tick.

Parameters:
TICK_DIV, 100000000, clk cycles per phase tick (≥1; 1 = tick every cycle)
T_MIN_GREEN, 5, minimum green length in ticks (≥1)
T_MAX_GREEN, 10, maximum green length in ticks (≥T_MIN_GREEN)
T_YELLOW, 3, yellow length in ticks (≥1)
T_ALLRED, 1, all-red clearance length in ticks (≥1)
T_REDYEL, 1, red+yellow length in ticks (≥1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sa  in  1  car waiting on road A (async, synchronised internally)
sb  in  1  car waiting on road B (async, synchronised internally)
maint  in  1  maintenance flash request (used only with FLASH_MODE_EN)
phase_idx  out  5  current phase code, to decoder input
phase_chg  out  1  one-cycle pulse in the first cycle of a new phase
lights_a  out  3  road A lamps {R,Y,G}
lights_b  out  3  road B lamps {R,Y,G}

Behaviour:
- Single clock clk; reset asynchronous active-high; all state clears immediately on reset assertion, no clock edge needed.
- Reset values: phase_idx=6, phase_chg=0, lights_a=3'b100, lights_b=3'b100, prescaler=0, dwell=0, synchronisers=0.
- sa/sb/maint: 2-flop synchronisers; a change is usable 2 clk later.
- Prescaler counts 0..TICK_DIV-1 and wraps; tick=1 during the cycle count==TICK_DIV-1.
- Dwell counter d = ticks elapsed in current phase; width $clog2(T_MAX_GREEN+1). All phase decisions happen only in tick cycles; otherwise state holds.
- Phases (phase_idx, lights_a, lights_b):
  0 A_GREEN 001/100; 1 A_YELLOW 010/100; 2 ALLRED_AB 100/100; 3 B_REDYEL 100/110;
  4 B_GREEN 100/001; 5 B_YELLOW 100/010; 6 ALLRED_BA 100/100; 7 A_REDYEL 110/100.
- Phase end on tick, with L = d+1:
  A_GREEN: (L≥T_MIN_GREEN and synced sb) or L≥T_MAX_GREEN; B_GREEN: same with sa.
  YELLOW: L==T_YELLOW; ALLRED: L==T_ALLRED; REDYEL: L==T_REDYEL.
  Order 0→1→2→3→4→5→6→7→0. On exit d←0, else d←d+1 (saturates at T_MAX_GREEN).
- sa and sb both high: the green holder yields at T_MIN_GREEN (strict alternation, no starvation).
- Prescaler is not reset on a phase change; every phase lasts an exact multiple of TICK_DIV cycles.
- phase_idx, lights, phase_chg registered; all update on the same edge. phase_chg=1 for exactly one cycle per transition; never asserted out of reset.
- phase_idx[4:3]=0 in normal phases; phase_idx never outside {0..7} (or {16,17} with feature).
- Reset mid-phase: immediate return to phase 6, d=0, prescaler=0; first tick lands TICK_DIV cycles after deassertion.

Optional Feature:
FLASH_MODE_EN defined: synced maint high at a tick → phase 16 FLASH_ON (lights 010/010), then alternate 16↔17 FLASH_OFF (000/000) every tick, phase_chg pulsing each change. maint overrides any phase including mid-yellow. maint low at a tick while in 16/17 → phase 6, d=0, then normal sequence.
FLASH_MODE_EN undefined: maint ignored, phases 16/17 unreachable, phase_idx[4]=0 permanently.

Test Plan:
(TICK_DIV=4, T_MIN_GREEN=3, T_MAX_GREEN=6, T_YELLOW=2, T_ALLRED=1, T_REDYEL=1)
- Reset, sa=sb=0 → phase_idx=6, lights 100/100; after 4 clk →7 (110/100) with phase_chg pulse; 4 clk later →0.
- No cars → A_GREEN lasts 24 clk, then 1 for 8 clk, 2 for 4, 3 for 4, B_GREEN 24; full cycle 0..7 in order, exactly 8 phase_chg pulses.
- sb held high from entry to A_GREEN → exits after 12 clk (3 ticks); sb pulsed for 1 clk only between ticks → ignored, exits at 24 clk.
- sa=sb=1 continuously → each green lasts exactly 12 clk, alternating A/B.
- Assert reset 2 clk into A_YELLOW, no clk edge → phase_idx=6, lights 100/100 immediately; sequence restarts as first scenario.
- FLASH_MODE_EN, maint=1 during B_GREEN → next tick phase_idx=16 (010/010), then 17 (000/000) every 4 clk; maint=0 → next tick phase 6, then 7, 0.
